rpn_stack_master: RTL
=====================

// Module: rpn_stack_master
// PURPOSE
//  Stack client that drives the 8-bit x 32 LIFO stack. Accepts a token stream (operands/operators)
//  over a valid/ready handshake and evaluates it as reverse-Polish arithmetic, issuing all
//  Push/Pop traffic to the stack and pushing each result back. Sole master of the stack; shares its Clk/RstN.
// PARAMETERS
//  DEPTH  32  stack capacity in entries; must equal the attached stack's capacity
//  DW     8   token/data width; must equal the stack's data width
// PORTS
//  Clk        in   1   rising-edge clock
//  RstN       in   1   asynchronous active-low reset; also wired to the stack
//  In_Valid   in   1   token present
//  In_Ready   out  1   token accepted when In_Valid & In_Ready at a Clk edge
//  In_IsOp    in   1   1 = In_Data[2:0] is an opcode, 0 = In_Data is an operand
//  In_Data    in   DW  operand value or opcode
//  St_Push    out  1   to stack Push
//  St_Pop     out  1   to stack Pop
//  St_Din     out  DW  to stack Data_In
//  St_Dout    in   DW  from stack Data_Out; valid the cycle after St_Pop is high
//  Res_Valid  out  1   1-cycle pulse: Result holds a new operator result
//  Result     out  DW  last operator result; holds until next result
//  Depth      out  6   entries currently on the stack (0..DEPTH)
//  Err        out  1   sticky error flag; cleared only by reset
//  Err_Code   out  2   0 none, 1 overflow, 2 underflow, 3 illegal opcode; first error wins
// BEHAVIOUR
//  - Reset (async, RstN=0): state IDLE, all outputs 0, Depth=0, A/B regs 0. A reset mid-sequence
//    aborts the sequence. The stack resets on the same RstN, so Depth stays consistent.
//  - Opcodes: 0 ADD A+B, 1 SUB A-B, 2 AND, 3 OR, 4 XOR, 5-7 illegal. A = deeper operand, B = top.
//    Arithmetic is modulo 2^DW. No carry or borrow output.
//  - All St_* outputs are registered. St_Push and St_Pop are never high together.
//  - Depth is tracked internally: +1 on each St_Push cycle, -1 on each St_Pop cycle. Stack Full/Empty are not used.
//  - FSM: IDLE, PUSH, POP_B, POP_A, EXEC, ERR.
//    IDLE: In_Ready=1. On accept:
//      operand & Depth<DEPTH                   -> PUSH
//      operand & Depth==DEPTH                  -> ERR (code 1); nothing is pushed
//      opcode>4                                -> ERR (code 3)
//      legal opcode & Depth<2                  -> ERR (code 2); stack untouched
//      legal opcode & Depth>=2                 -> POP_B; latch opcode
//    PUSH:  St_Push=1, St_Din=operand             -> IDLE  (operand costs 2 cycles)
//    POP_B: St_Pop=1                              -> POP_A
//    POP_A: St_Pop=1; B<=St_Dout                  -> EXEC
//    EXEC:  A<=St_Dout; result=alu(A,B); next cycle St_Push=1, St_Din=result,
//           Result=result, Res_Valid=1            -> IDLE
//    Net stack effect of an operator: -1 entry. Operator latency: accept edge to Res_Valid = 4 cycles.
//    ERR:   In_Ready=1; tokens are accepted and discarded; no stack traffic; terminal until reset.
//  - In_Ready=0 in PUSH/POP_B/POP_A/EXEC. In_Data and In_IsOp are sampled only at the accept edge.
//  - Boundaries:
//    Depth==DEPTH allows an operator (net -1) but not an operand.
//    Depth==2 operator leaves Depth=1.
//    In_Valid held high while not ready: no token is lost or duplicated.
// STRUCTURE
//  - Include file rpn_defs.vh: opcode localparams, Err_Code values, FSM state encoding, DEPTH/DW defaults.
//  - Sub-module rpn_alu: combinational; inputs (op[2:0], a, b), outputs (y, illegal).
//  - Top holds the FSM, Depth counter, A/B/opcode registers and the error logic.
// TESTING (bench instantiates rpn_stack_master + the stack, shared Clk/RstN)
//  1. Tokens 7, 5, SUB -> Res_Valid 4 cycles after SUB accept, Result=2, Depth=1.
//     Then 3, ADD -> Result=5, Depth=1.
//  2. Tokens 3, 5, SUB -> Result=8'hFE (wrap).
//     Then 8'hFF, 8'h02, ADD -> Result=8'h01.
//  3. Token ADD at Depth=1 -> Err=1, Err_Code=2, Depth stays 1, no St_Pop ever asserted.
//  4. Push 32 operands (Depth=32), then a 33rd -> Err_Code=1, no St_Push.
//     Separate run: Depth=32 then XOR -> Depth=31, no error.
//  5. Opcode 6 -> Err_Code=3.
//     Subsequent tokens accepted with In_Ready=1, no St_* activity, Result unchanged.
//  6. Assert RstN=0 during POP_A -> outputs 0 immediately (async), Depth=0.
//     After release, 4, 4, AND -> Result=4.

Source files
------------

// File: rtl/rpn_stack_master_pkg.sv
// Shared constants for the RPN stack master: sizing defaults, opcodes, error codes, FSM encoding.
package rpn_stack_master_pkg;

  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned DEPTH_W   = 6;
  localparam int unsigned OP_W      = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_ILL  = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PUSH  = 3'd1;
  localparam logic [2:0] S_POP_B = 3'd2;
  localparam logic [2:0] S_POP_A = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

endpackage

// File: rtl/rpn_alu.sv
// Combinational operator unit: a is the deeper operand, b the top of stack; wraps modulo 2^DW.
module rpn_alu
  import rpn_stack_master_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [OP_W-1:0] i_op,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic [DW-1:0]   o_y,
  output logic            o_illegal
);

  always_comb begin
    o_y       = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rpn_stack_master.sv
// Reverse-Polish evaluator that is the sole master of an external LIFO stack.
// All outputs are registered; the comb block computes their next values alongside the next state.
module rpn_stack_master
  import rpn_stack_master_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic               In_IsOp,
  input  logic [DW-1:0]      In_Data,
  output logic               St_Push,
  output logic               St_Pop,
  output logic [DW-1:0]      St_Din,
  input  logic [DW-1:0]      St_Dout,
  output logic               Res_Valid,
  output logic [DW-1:0]      Result,
  output logic [DEPTH_W-1:0] Depth,
  output logic               Err,
  output logic [1:0]         Err_Code
);

  logic [2:0]         r_state, w_state_nxt;
  logic [DW-1:0]      r_data, r_a, r_b;
  logic [OP_W-1:0]    r_op;
  logic               r_is_res;

  logic [DW-1:0]      w_data_nxt, w_a_nxt, w_b_nxt;
  logic [OP_W-1:0]    w_op_nxt;
  logic               w_is_res_nxt;
  logic               w_ready_nxt, w_push_nxt, w_pop_nxt, w_res_valid_nxt, w_err_nxt;
  logic [DW-1:0]      w_din_nxt, w_result_nxt;
  logic [DEPTH_W-1:0] w_depth_nxt;
  logic [1:0]         w_err_code_nxt;

  logic               w_accept;
  logic [OP_W-1:0]    w_alu_op;
  logic [DW-1:0]      w_alu_y;
  logic               w_alu_illegal;

  assign w_accept = In_Valid & In_Ready;
  // In IDLE the ALU only classifies the incoming opcode; otherwise it evaluates the latched operator.
  assign w_alu_op = (r_state == S_IDLE) ? In_Data[OP_W-1:0] : r_op;

  rpn_alu #(.DW(DW)) u_alu (
    .i_op      (w_alu_op),
    .i_a       (r_a),
    .i_b       (r_b),
    .o_y       (w_alu_y),
    .o_illegal (w_alu_illegal)
  );

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_data_nxt      = r_data;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_op_nxt        = r_op;
    w_is_res_nxt    = r_is_res;
    w_push_nxt      = 1'b0;
    w_pop_nxt       = 1'b0;
    w_din_nxt       = St_Din;
    w_res_valid_nxt = 1'b0;
    w_result_nxt    = Result;
    w_depth_nxt     = Depth;
    w_err_nxt       = Err;
    w_err_code_nxt  = Err_Code;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!In_IsOp) begin
            if (Depth < DEPTH_W'(DEPTH)) begin
              w_state_nxt  = S_PUSH;
              w_data_nxt   = In_Data;
              w_is_res_nxt = 1'b0;
            end else begin
              w_state_nxt    = S_ERR;
              w_err_nxt      = 1'b1;
              w_err_code_nxt = ERR_OVF;
            end
          end else if (w_alu_illegal) begin
            w_state_nxt    = S_ERR;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_ILL;
          end else if (Depth < DEPTH_W'(2)) begin
            w_state_nxt    = S_ERR;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_UNF;
          end else begin
            w_state_nxt = S_POP_B;
            w_op_nxt    = In_Data[OP_W-1:0];
            w_pop_nxt   = 1'b1;
            w_depth_nxt = Depth - DEPTH_W'(1);
          end
        end
      end
      S_PUSH: begin
        w_state_nxt = S_IDLE;
        w_push_nxt  = 1'b1;
        w_depth_nxt = Depth + DEPTH_W'(1);
        if (r_is_res) begin
          w_din_nxt       = w_alu_y;
          w_result_nxt    = w_alu_y;
          w_res_valid_nxt = 1'b1;
        end else begin
          w_din_nxt = r_data;
        end
      end
      S_POP_B: begin
        w_state_nxt = S_POP_A;
        w_pop_nxt   = 1'b1;
        w_depth_nxt = Depth - DEPTH_W'(1);
      end
      S_POP_A: begin
        w_state_nxt = S_EXEC;
        w_b_nxt     = St_Dout;
      end
      S_EXEC: begin
        w_state_nxt  = S_PUSH;
        w_a_nxt      = St_Dout;
        w_is_res_nxt = 1'b1;
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_ERR);
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_is_res  <= 1'b0;
      In_Ready  <= 1'b0;
      St_Push   <= 1'b0;
      St_Pop    <= 1'b0;
      St_Din    <= '0;
      Res_Valid <= 1'b0;
      Result    <= '0;
      Depth     <= '0;
      Err       <= 1'b0;
      Err_Code  <= ERR_NONE;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_op      <= w_op_nxt;
      r_is_res  <= w_is_res_nxt;
      In_Ready  <= w_ready_nxt;
      St_Push   <= w_push_nxt;
      St_Pop    <= w_pop_nxt;
      St_Din    <= w_din_nxt;
      Res_Valid <= w_res_valid_nxt;
      Result    <= w_result_nxt;
      Depth     <= w_depth_nxt;
      Err       <= w_err_nxt;
      Err_Code  <= w_err_code_nxt;
    end
  end

endmodule
